// File: rtl/tm_qm_pkg.sv
// Shared types and width helpers for the traffic-manager queue-manager
// linked-list engine (tm_qm_ll_pgen and its free-list sub-block).
package tm_qm_pkg;

    typedef enum logic [0:0] {
        QM_INIT = 1'b0,
        QM_RUN  = 1'b1
    } qm_ll_state_e;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int qm_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter width able to hold the value n itself.
    function automatic int qm_cnt_w(input int n);
        return qm_w(n) + 1;
    endfunction

    // Registered ack stage flags. The ack qid travels beside this bundle
    // because its width follows the NUM_Q parameter of the instance.
    // miss:     enq -> descriptor dropped,  deq -> queue was empty
    // boundary: enq -> queue was empty,     deq -> queue is now empty
    typedef struct packed {
        logic valid;
        logic miss;
        logic boundary;
    } qm_ack_t;

endpackage

// File: rtl/tm_qm_freelist.sv
// Free-buffer list controller: self-initialising sequencer plus the
// free_head / free_tail / freeq_count registers. The next-pointer memory
// lives in the parent; this block drives its init and link writes.
module tm_qm_freelist
    import tm_qm_pkg::*;
#(
    parameter  int NUM_BUF = 256,
    localparam int BUF_W   = qm_w(NUM_BUF),
    localparam int CNT_W   = qm_cnt_w(NUM_BUF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc,
    input  logic             rel,
    input  logic [BUF_W-1:0] rel_buf,
    input  logic [BUF_W-1:0] next_of_head,
    output logic             init_done,
    output logic             init_wr,
    output logic [BUF_W-1:0] init_idx,
    output logic [BUF_W-1:0] free_head,
    output logic [BUF_W-1:0] free_tail,
    output logic             link_wr,
    output logic [CNT_W-1:0] freeq_count
);

    qm_ll_state_e     state;
    logic [BUF_W-1:0] idx;
    logic             init_last;
    logic             one_left;

    assign init_last = (idx == BUF_W'(NUM_BUF - 1));
    assign one_left  = (freeq_count == CNT_W'(1));
    assign init_done = (state == QM_RUN) && !reset;
    assign init_wr   = (state == QM_INIT) && !reset;
    assign init_idx  = idx;
    // Appending behind free_tail is only valid when the list stays non-empty
    // through the cycle; the empty and last-buffer cases rebuild the list.
    assign link_wr   = rel && (freeq_count != '0) && !(alloc && one_left);

    // Init sequencing, then alloc from head / release to tail
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= QM_INIT;
            idx         <= '0;
            free_head   <= '0;
            free_tail   <= '0;
            freeq_count <= '0;
        end else if (state == QM_INIT) begin
            idx <= idx + BUF_W'(1);
            if (init_last) begin
                free_head   <= '0;
                free_tail   <= BUF_W'(NUM_BUF - 1);
                freeq_count <= CNT_W'(NUM_BUF);
                state       <= QM_RUN;
            end
        end else begin
            freeq_count <= freeq_count + CNT_W'(rel) - CNT_W'(alloc);
            if (alloc && rel && one_left) begin
                // The only free buffer leaves; the released one is the list.
                free_head <= rel_buf;
                free_tail <= rel_buf;
            end else begin
                if (alloc) begin
                    free_head <= next_of_head;
                end
                if (rel) begin
                    if (freeq_count == '0) begin
                        free_head <= rel_buf;
                    end
                    free_tail <= rel_buf;
                end
            end
        end
    end

endmodule

// File: rtl/tm_qm_ll_pgen.sv
// Queue-manager linked-list engine: NUM_Q per-queue FIFOs of opaque
// descriptors built from a shared buffer pool via a next-pointer memory.
// Optional macro TM_QM_LL_QLIMIT_EN adds a per-enqueue q_limit check.
module tm_qm_ll_pgen
    import tm_qm_pkg::*;
#(
    parameter  int NUM_Q   = 64,
    parameter  int NUM_BUF = 256,
    parameter  int DESC_W  = 32,
    localparam int QID_W   = qm_w(NUM_Q),
    localparam int BUF_W   = qm_w(NUM_BUF)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_done,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [QID_W-1:0]  enq_qid,
    input  logic [DESC_W-1:0] enq_desc,
    output logic              enq_ack,
    output logic              enq_drop,
    output logic [QID_W-1:0]  enq_ack_qid,
    output logic              enq_to_empty,
    input  logic              deq_valid,
    output logic              deq_ready,
    input  logic [QID_W-1:0]  deq_qid,
`ifdef TM_QM_LL_QLIMIT_EN
    input  logic [BUF_W:0]    q_limit,
`endif
    output logic              deq_ack,
    output logic [QID_W-1:0]  deq_ack_qid,
    output logic [DESC_W-1:0] deq_desc,
    output logic              deq_err,
    output logic              deq_last,
    output logic [BUF_W:0]    freeq_count
);

    logic [BUF_W-1:0]  next_mem [NUM_BUF];
    logic [DESC_W-1:0] desc_mem [NUM_BUF];
    logic [BUF_W-1:0]  head_mem [NUM_Q];
    logic [BUF_W-1:0]  tail_mem [NUM_Q];
    logic [BUF_W:0]    qcnt     [NUM_Q];

    logic [BUF_W-1:0] free_head, free_tail, init_idx, rel_buf, deq_next_head;
    logic             init_wr, link_wr;
    logic             enq_fire, deq_fire, enq_full, enq_ok, deq_ok, same_q;
    logic [BUF_W:0]   enq_cnt, deq_cnt;
    qm_ack_t          enq_ack_q, deq_ack_q;

    assign enq_ready = init_done;
    assign deq_ready = init_done;
    assign enq_fire  = enq_valid && init_done;
    assign deq_fire  = deq_valid && init_done;
    assign enq_cnt   = qcnt[enq_qid];
    assign deq_cnt   = qcnt[deq_qid];
`ifdef TM_QM_LL_QLIMIT_EN
    assign enq_full  = (freeq_count == '0) || ((q_limit != '0) && (enq_cnt >= q_limit));
`else
    assign enq_full  = (freeq_count == '0);
`endif
    assign enq_ok    = enq_fire && !enq_full;
    assign deq_ok    = deq_fire && (deq_cnt != '0);
    assign same_q    = (enq_qid == deq_qid);
    assign rel_buf   = head_mem[deq_qid];
    // Popping the sole entry while the same queue is appended: the new head
    // is the buffer being allocated this cycle (write-first on next[tail]).
    assign deq_next_head = (enq_ok && same_q && deq_cnt == (BUF_W+1)'(1)) ? free_head
                                                                          : next_mem[rel_buf];

    assign enq_ack      = enq_ack_q.valid;
    assign enq_drop     = enq_ack_q.miss;
    assign enq_to_empty = enq_ack_q.boundary;
    assign deq_ack      = deq_ack_q.valid;
    assign deq_err      = deq_ack_q.miss;
    assign deq_last     = deq_ack_q.boundary;

    tm_qm_freelist #(
        .NUM_BUF (NUM_BUF)
    ) u_freelist (
        .clk          (clk),
        .reset        (reset),
        .alloc        (enq_ok),
        .rel          (deq_ok),
        .rel_buf      (rel_buf),
        .next_of_head (next_mem[free_head]),
        .init_done    (init_done),
        .init_wr      (init_wr),
        .init_idx     (init_idx),
        .free_head    (free_head),
        .free_tail    (free_tail),
        .link_wr      (link_wr),
        .freeq_count  (freeq_count)
    );

    // Link memories: init chain, enqueue append, dequeue head advance, free-list append
    always_ff @(posedge clk) begin
        if (init_wr) begin
            next_mem[init_idx] <= init_idx + BUF_W'(1);
        end
        if (enq_ok) begin
            desc_mem[free_head] <= enq_desc;
            if (enq_cnt == '0) begin
                head_mem[enq_qid] <= free_head;
            end else begin
                next_mem[tail_mem[enq_qid]] <= free_head;
            end
            tail_mem[enq_qid] <= free_head;
        end
        if (link_wr) begin
            next_mem[free_tail] <= rel_buf;
        end
        if (deq_ok) begin
            head_mem[deq_qid] <= deq_next_head;
        end
    end

    // Per-queue depth: cleared during init, net change when both sides hit one queue
    always_ff @(posedge clk) begin
        if (init_wr) begin
            if ({1'b0, init_idx} < (BUF_W+1)'(NUM_Q)) begin
                qcnt[init_idx[QID_W-1:0]] <= '0;
            end
        end else if (!(enq_ok && deq_ok && same_q)) begin
            if (enq_ok) begin
                qcnt[enq_qid] <= enq_cnt + (BUF_W+1)'(1);
            end
            if (deq_ok) begin
                qcnt[deq_qid] <= deq_cnt - (BUF_W+1)'(1);
            end
        end
    end

    // Registered completion stages, one cycle after accept
    always_ff @(posedge clk) begin
        if (reset) begin
            enq_ack_q   <= '0;
            deq_ack_q   <= '0;
            enq_ack_qid <= '0;
            deq_ack_qid <= '0;
            deq_desc    <= '0;
        end else begin
            enq_ack_q   <= '{valid: enq_fire, miss: enq_fire && enq_full,
                             boundary: enq_ok && (enq_cnt == '0)};
            deq_ack_q   <= '{valid: deq_fire, miss: deq_fire && (deq_cnt == '0),
                             boundary: deq_ok && (deq_cnt == (BUF_W+1)'(1)) && !(enq_ok && same_q)};
            enq_ack_qid <= enq_fire ? enq_qid : '0;
            deq_ack_qid <= deq_fire ? deq_qid : '0;
            deq_desc    <= deq_ok ? desc_mem[rel_buf] : '0;
        end
    end

endmodule

// File: tb/tb_tm_qm_ll_pgen.sv
// Directed bench for tm_qm_ll_pgen with a queue-based reference model and
// expected-ack scoreboard. Define TM_QM_LL_QLIMIT_EN to cover q_limit.
module tb_tm_qm_ll_pgen;

    localparam int NUM_Q   = 64;
    localparam int NUM_BUF = 256;
    localparam int DESC_W  = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic        enq_valid, enq_ready, enq_ack, enq_drop, enq_to_empty;
    logic [5:0]  enq_qid, enq_ack_qid;
    logic [31:0] enq_desc;
    logic        deq_valid, deq_ready, deq_ack, deq_err, deq_last;
    logic [5:0]  deq_qid, deq_ack_qid;
    logic [31:0] deq_desc;
    logic [8:0]  freeq_count;
`ifdef TM_QM_LL_QLIMIT_EN
    logic [8:0]  q_limit;
`endif

    always #5 clk = ~clk;

    tm_qm_ll_pgen #(
        .NUM_Q   (NUM_Q),
        .NUM_BUF (NUM_BUF),
        .DESC_W  (DESC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init_done    (init_done),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_qid      (enq_qid),
        .enq_desc     (enq_desc),
        .enq_ack      (enq_ack),
        .enq_drop     (enq_drop),
        .enq_ack_qid  (enq_ack_qid),
        .enq_to_empty (enq_to_empty),
        .deq_valid    (deq_valid),
        .deq_ready    (deq_ready),
        .deq_qid      (deq_qid),
`ifdef TM_QM_LL_QLIMIT_EN
        .q_limit      (q_limit),
`endif
        .deq_ack      (deq_ack),
        .deq_ack_qid  (deq_ack_qid),
        .deq_desc     (deq_desc),
        .deq_err      (deq_err),
        .deq_last     (deq_last),
        .freeq_count  (freeq_count)
    );

    typedef struct {
        int          qid;
        bit          a;
        bit          b;
        logic [31:0] desc;
    } exp_t;

    exp_t        exp_enq[$];
    exp_t        exp_deq[$];
    logic [31:0] mq [NUM_Q][$];
    int          mfree = 0;
    int          mlim  = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        exp_t x;
        if (exp_enq.size() > 0) begin
            x = exp_enq.pop_front();
            chk("enq_ack", 64'(enq_ack), 64'd1);
            chk("enq_drop", 64'(enq_drop), 64'(x.a));
            chk("enq_to_empty", 64'(enq_to_empty), 64'(x.b));
            chk("enq_ack_qid", 64'(enq_ack_qid), 64'(x.qid));
        end else begin
            chk("enq_ack_idle", 64'(enq_ack), 64'd0);
        end
        if (exp_deq.size() > 0) begin
            x = exp_deq.pop_front();
            chk("deq_ack", 64'(deq_ack), 64'd1);
            chk("deq_err", 64'(deq_err), 64'(x.a));
            chk("deq_last", 64'(deq_last), 64'(x.b));
            chk("deq_ack_qid", 64'(deq_ack_qid), 64'(x.qid));
            chk("deq_desc", 64'(deq_desc), 64'(x.desc));
        end else begin
            chk("deq_ack_idle", 64'(deq_ack), 64'd0);
        end
        chk("freeq_count", 64'(freeq_count), 64'(mfree));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Drive one cycle of requests, predict the acks from the model, check them.
    task automatic xfer(input bit e, input int eq, input logic [31:0] ed,
                        input bit d, input int dq);
        exp_t x;
        int   pre_e, pre_d;
        bit   drop, err;
        enq_valid = e;
        enq_qid   = 6'(eq);
        enq_desc  = ed;
        deq_valid = d;
        deq_qid   = 6'(dq);
        pre_e = mq[eq].size();
        pre_d = mq[dq].size();
        drop  = (mfree == 0) || (mlim != 0 && pre_e >= mlim);
        err   = (pre_d == 0);
        x.qid = dq;
        x.a   = err;
        x.b   = 1'b0;
        x.desc = '0;
        if (d && !err) begin
            x.desc = mq[dq].pop_front();
            mfree++;
        end
        if (e && !drop) begin
            mq[eq].push_back(ed);
            mfree--;
        end
        if (d) begin
            x.b = !err && (mq[dq].size() == 0);
            exp_deq.push_back(x);
        end
        if (e) begin
            x.qid  = eq;
            x.a    = drop;
            x.b    = !drop && (pre_e == 0);
            x.desc = '0;
            exp_enq.push_back(x);
        end
        step();
        enq_valid = 1'b0;
        deq_valid = 1'b0;
    endtask

    task automatic drain(input int q);
        while (mq[q].size() > 0) xfer(1'b0, 0, 32'h0, 1'b1, q);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        enq_valid = 1'b0;
        deq_valid = 1'b0;
        enq_qid   = '0;
        deq_qid   = '0;
        enq_desc  = '0;
`ifdef TM_QM_LL_QLIMIT_EN
        q_limit   = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd0);
        chk("rst_deq_ready", 64'(deq_ready), 64'd0);
        chk("rst_enq_ack", 64'(enq_ack), 64'd0);
        chk("rst_deq_ack", 64'(deq_ack), 64'd0);
        chk("rst_deq_desc", 64'(deq_desc), 64'd0);
        chk("rst_freeq_count", 64'(freeq_count), 64'd0);

        // Free-list build: ready exactly NUM_BUF cycles after reset release
        reset = 1'b0;
        n = 0;
        while (!init_done && n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("init_cycles", 64'(n), 64'(NUM_BUF));
        chk("init_enq_ready", 64'(enq_ready), 64'd1);
        chk("init_deq_ready", 64'(deq_ready), 64'd1);
        mfree = NUM_BUF;
        chk("init_freeq_count", 64'(freeq_count), 64'(NUM_BUF));

        // FIFO order on one queue
        xfer(1'b1, 5, 32'hA1, 1'b0, 0);
        xfer(1'b1, 5, 32'hA2, 1'b0, 0);
        xfer(1'b1, 5, 32'hA3, 1'b0, 0);
        repeat (3) xfer(1'b0, 0, 32'h0, 1'b1, 5);

        // Pool exhaustion, then recovery through the last-buffer corner
        for (int i = 0; i < NUM_BUF; i++) xfer(1'b1, i % 4, 32'h1000 + 32'(i), 1'b0, 0);
        xfer(1'b1, 0, 32'hDEAD, 1'b0, 0);
        xfer(1'b0, 0, 32'h0, 1'b1, 0);
        xfer(1'b1, 3, 32'hBEEF, 1'b1, 1);
        xfer(1'b1, 2, 32'hCAFE, 1'b0, 0);
        for (int q = 0; q < 4; q++) drain(q);

        // Same-queue enq+deq with one entry present
        xfer(1'b1, 7, 32'h11, 1'b0, 0);
        xfer(1'b1, 7, 32'h22, 1'b1, 7);
        xfer(1'b0, 0, 32'h0, 1'b1, 7);

        // Same-queue enq+deq on an empty queue
        xfer(1'b1, 9, 32'h33, 1'b1, 9);
        xfer(1'b0, 0, 32'h0, 1'b1, 9);

        // Lone empty dequeue and concurrent traffic on different queues
        xfer(1'b0, 0, 32'h0, 1'b1, 20);
        xfer(1'b1, 30, 32'h44, 1'b1, 31);
        xfer(1'b1, 31, 32'h55, 1'b1, 30);
        xfer(1'b1, 30, 32'h66, 1'b1, 31);
        drain(30);

`ifdef TM_QM_LL_QLIMIT_EN
        q_limit = 9'd2;
        mlim    = 2;
        repeat (3) xfer(1'b1, 1, 32'h77, 1'b0, 0);
        chk("qlimit_freeq", 64'(freeq_count), 64'(NUM_BUF - 2));
        drain(1);
        q_limit = 9'd0;
        mlim    = 0;
        xfer(1'b1, 1, 32'h81, 1'b0, 0);
        xfer(1'b1, 1, 32'h82, 1'b0, 0);
        xfer(1'b1, 1, 32'h83, 1'b0, 0);
        drain(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
